// File: rtl/wb_arbiter_if.sv
// Bus bundle between two Wishbone-style masters, the arbiter and shared memory.
// slave: the arbiter's view. master: the view of the environment driving requests and memory responses.
interface wb_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 128,
    parameter int SEL_W  = 16
);
    logic              i_cyc;
    logic              i_stb;
    logic              i_we;
    logic [ADDR_W-1:0] i_adr;
    logic [DATA_W-1:0] i_dat_m;
    logic [SEL_W-1:0]  i_sel;
    logic [DATA_W-1:0] i_dat_s;
    logic              i_ack;

    logic              d_cyc;
    logic              d_stb;
    logic              d_we;
    logic [ADDR_W-1:0] d_adr;
    logic [DATA_W-1:0] d_dat_m;
    logic [SEL_W-1:0]  d_sel;
    logic [DATA_W-1:0] d_dat_s;
    logic              d_ack;

    logic              m_cyc;
    logic              m_stb;
    logic              m_we;
    logic [ADDR_W-1:0] m_adr;
    logic [DATA_W-1:0] m_dat_m;
    logic [SEL_W-1:0]  m_sel;
    logic [DATA_W-1:0] m_dat_s;
    logic              m_ack;

    modport slave (
        input  i_cyc, i_stb, i_we, i_adr, i_dat_m, i_sel,
        output i_dat_s, i_ack,
        input  d_cyc, d_stb, d_we, d_adr, d_dat_m, d_sel,
        output d_dat_s, d_ack,
        output m_cyc, m_stb, m_we, m_adr, m_dat_m, m_sel,
        input  m_dat_s, m_ack
    );

    modport master (
        output i_cyc, i_stb, i_we, i_adr, i_dat_m, i_sel,
        input  i_dat_s, i_ack,
        output d_cyc, d_stb, d_we, d_adr, d_dat_m, d_sel,
        input  d_dat_s, d_ack,
        input  m_cyc, m_stb, m_we, m_adr, m_dat_m, m_sel,
        output m_dat_s, m_ack
    );
endinterface

// File: rtl/wb_arbiter.sv
// Round-robin arbiter sharing one memory port between the instruction-fetch and data masters.
// One transaction in flight; the response is returned to the owner as a single-cycle ack.
module wb_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 128,
    parameter int SEL_W  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    wb_arbiter_if.slave bus
);
    // state  | meaning
    // IDLE   | no transaction; pick a requester
    // BUSY_I | memory cycle on behalf of the instruction-fetch master
    // BUSY_D | memory cycle on behalf of the data master
    // DONE   | owner's ack cycle, response presented on its dat_s
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

    state_t state_q, state_d;

    logic              last_d_q;
    logic              owner_d_q;
    logic              abort_q;
    logic [ADDR_W-1:0] adr_q;
    logic [DATA_W-1:0] wdat_q;
    logic [SEL_W-1:0]  sel_q;
    logic              we_q;
    logic [DATA_W-1:0] resp_q;
    logic [DATA_W-1:0] i_hold_q;
    logic [DATA_W-1:0] d_hold_q;

    logic i_req, d_req, busy, owner_cyc, abort_now;
    logic grant_i, grant_d, capture, done_i, done_d;

    assign i_req     = bus.i_cyc & bus.i_stb;
    assign d_req     = bus.d_cyc & bus.d_stb;
    assign busy      = (state_q == BUSY_I) || (state_q == BUSY_D);
    assign owner_cyc = owner_d_q ? bus.d_cyc : bus.i_cyc;
    // once the owner lets go of cyc the cycle is an abort, even if it reasserts later
    assign abort_now = abort_q | ~owner_cyc;
    assign done_i    = (state_q == DONE) & ~owner_d_q;
    assign done_d    = (state_q == DONE) & owner_d_q;

    always_comb begin
        state_d = state_q;
        grant_i = 1'b0;
        grant_d = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_req && (!d_req || last_d_q)) begin
                    grant_i = 1'b1;
                    state_d = BUSY_I;
                end else if (d_req) begin
                    grant_d = 1'b1;
                    state_d = BUSY_D;
                end
            end
            BUSY_I, BUSY_D: begin
                if (bus.m_ack) begin
                    capture = ~abort_now;
                    state_d = abort_now ? IDLE : DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            last_d_q  <= 1'b0;
            owner_d_q <= 1'b0;
            abort_q   <= 1'b0;
            adr_q     <= '0;
            wdat_q    <= '0;
            sel_q     <= '0;
            we_q      <= 1'b0;
            resp_q    <= '0;
            i_hold_q  <= '0;
            d_hold_q  <= '0;
        end else begin
            state_q <= state_d;
            if (grant_i || grant_d) begin
                owner_d_q <= grant_d;
                abort_q   <= 1'b0;
                adr_q     <= grant_d ? bus.d_adr   : bus.i_adr;
                wdat_q    <= grant_d ? bus.d_dat_m : bus.i_dat_m;
                sel_q     <= grant_d ? bus.d_sel   : bus.i_sel;
                we_q      <= grant_d ? bus.d_we    : bus.i_we;
            end
            if (busy) begin
                abort_q <= abort_now;
                if (bus.m_ack) last_d_q <= owner_d_q;
            end
            if (capture) resp_q <= bus.m_dat_s;
            // per-master copies keep each dat_s stable while the other master is served
            if (done_i) i_hold_q <= resp_q;
            if (done_d) d_hold_q <= resp_q;
        end
    end

    assign bus.m_cyc   = busy;
    assign bus.m_stb   = busy;
    assign bus.m_we    = we_q;
    assign bus.m_adr   = adr_q;
    assign bus.m_dat_m = wdat_q;
    assign bus.m_sel   = sel_q;

    assign bus.i_ack   = done_i;
    assign bus.d_ack   = done_d;
    assign bus.i_dat_s = done_i ? resp_q : i_hold_q;
    assign bus.d_dat_s = done_d ? resp_q : d_hold_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed vectors, corner-case sequences and a
// randomized run scored against a transaction-level round-robin model.
module tb_wb_arbiter;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 128;
    localparam int SEL_W  = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    wb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEL_W(SEL_W)) bus ();

    wb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEL_W(SEL_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    bit           mem_hold  = 1'b0;
    bit           mem_rand  = 1'b0;
    bit           fixed_en  = 1'b1;
    bit           stray_ack = 1'b0;
    int           mem_lat   = 0;
    logic [127:0] fixed_dat = '0;
    logic [31:0]  mem_salt  = 32'h1357_9BDF;

    typedef struct {
        string        name;
        bit           use_d;
        logic         we;
        logic [11:0]  adr;
        logic [15:0]  sel;
        logic [127:0] wdat;
        int           lat;
        logic [127:0] rdat;
        int           exp_ack_cyc;
        logic [127:0] exp_dat;
    } vec_t;

    vec_t vecs[5];
    vec_t rst_vec;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] mem_word(input logic [11:0] a);
        logic [31:0] w;
        w = mem_salt ^ ({20'h0, a} * 32'h9E37_79B1);
        return {w, ~w, w ^ 32'h5A5A_5A5A, {a, a, a[7:0]}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_master(input bit m, input logic on, input logic we, input logic [11:0] adr,
                              input logic [15:0] sel, input logic [127:0] dat);
        if (!m) begin
            bus.i_cyc = on; bus.i_stb = on; bus.i_we = we;
            bus.i_adr = adr; bus.i_sel = sel; bus.i_dat_m = dat;
        end else begin
            bus.d_cyc = on; bus.d_stb = on; bus.d_we = we;
            bus.d_adr = adr; bus.d_sel = sel; bus.d_dat_m = dat;
        end
    endtask

    task automatic zero_check(input string nm);
        chk({nm, ".m_ctl"},   128'({bus.m_cyc, bus.m_stb, bus.m_we}), 128'(0));
        chk({nm, ".m_adr"},   128'(bus.m_adr), 128'(0));
        chk({nm, ".m_dat_m"}, bus.m_dat_m, 128'(0));
        chk({nm, ".m_sel"},   128'(bus.m_sel), 128'(0));
        chk({nm, ".acks"},    128'({bus.i_ack, bus.d_ack}), 128'(0));
        chk({nm, ".i_dat_s"}, bus.i_dat_s, 128'(0));
        chk({nm, ".d_dat_s"}, bus.d_dat_s, 128'(0));
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Shared memory: acks after a per-transaction latency counted from the first m_stb cycle.
    initial begin
        int cnt;
        int cur_lat;
        cnt = 0;
        cur_lat = 0;
        bus.m_ack = 1'b0;
        bus.m_dat_s = '0;
        forever begin
            @(posedge clk);
            #2;
            bus.m_ack = 1'b0;
            if (bus.m_stb && !mem_hold) begin
                if (cnt == 0) cur_lat = mem_rand ? int'($urandom_range(0, 4)) : mem_lat;
                if (cnt >= cur_lat) begin
                    bus.m_ack = 1'b1;
                    bus.m_dat_s = fixed_en ? fixed_dat : mem_word(bus.m_adr);
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
            if (stray_ack) bus.m_ack = 1'b1;
        end
    end

    // Protocol invariants checked every cycle.
    initial begin
        logic        p_stb;
        logic [11:0] h_adr;
        logic [15:0] h_sel;
        logic        h_we;
        logic [127:0] h_dat;
        p_stb = 1'b0;
        h_adr = '0; h_sel = '0; h_we = 1'b0; h_dat = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                chk("ack_overlap", 128'(bus.i_ack & bus.d_ack), 128'(0));
                chk("cyc_eq_stb", 128'(bus.m_cyc), 128'(bus.m_stb));
                if (bus.m_stb && p_stb) begin
                    chk("hold_ctl", 128'({bus.m_adr, bus.m_sel, bus.m_we}), 128'({h_adr, h_sel, h_we}));
                    chk("hold_dat", bus.m_dat_m, h_dat);
                end
            end
            p_stb = bus.m_stb;
            h_adr = bus.m_adr; h_sel = bus.m_sel; h_we = bus.m_we; h_dat = bus.m_dat_m;
        end
    end

    task automatic run_vec(input vec_t v);
        bit seen_stb;
        bit got_ack;
        int c;
        logic own_ack, oth_ack;
        logic [127:0] own_dat;
        fixed_en = 1'b1; fixed_dat = v.rdat; mem_lat = v.lat; mem_rand = 1'b0;
        set_master(v.use_d, 1'b1, v.we, v.adr, v.sel, v.wdat);
        seen_stb = 1'b0;
        got_ack = 1'b0;
        c = 0;
        while (!got_ack && c < 40) begin
            tick();
            c++;
            own_ack = v.use_d ? bus.d_ack : bus.i_ack;
            oth_ack = v.use_d ? bus.i_ack : bus.d_ack;
            own_dat = v.use_d ? bus.d_dat_s : bus.i_dat_s;
            if (bus.m_stb && !seen_stb) begin
                seen_stb = 1'b1;
                chk({v.name, ".stb_cyc"}, 128'(c), 128'(1));
                chk({v.name, ".m_adr"},   128'(bus.m_adr), 128'(v.adr));
                chk({v.name, ".m_we"},    128'(bus.m_we), 128'(v.we));
                chk({v.name, ".m_sel"},   128'(bus.m_sel), 128'(v.sel));
                chk({v.name, ".m_dat_m"}, bus.m_dat_m, v.wdat);
            end
            chk({v.name, ".other_ack"}, 128'(oth_ack), 128'(0));
            if (own_ack) begin
                got_ack = 1'b1;
                chk({v.name, ".ack_cyc"}, 128'(c), 128'(v.exp_ack_cyc));
                chk({v.name, ".dat_s"}, own_dat, v.exp_dat);
                set_master(v.use_d, 1'b0, 1'b0, 12'h0, 16'h0, '0);
            end
        end
        if (!got_ack) begin
            chk({v.name, ".ack_timeout"}, 128'(got_ack), 128'(1));
            set_master(v.use_d, 1'b0, 1'b0, 12'h0, 16'h0, '0);
        end
        tick();
        chk({v.name, ".ack_pulse"}, 128'(v.use_d ? bus.d_ack : bus.i_ack), 128'(0));
        chk({v.name, ".dat_hold"}, v.use_d ? bus.d_dat_s : bus.i_dat_s, v.exp_dat);
        tick();
    endtask

    // Both masters keep requesting until each has been served quota times; acks must alternate D,I,...
    task automatic run_pair(input string nm, input int quota);
        int cnt[2];
        bit up[2];
        logic [11:0] adr[2];
        int served;
        bit exp_d;
        logic ackv;
        fixed_en = 1'b0; mem_rand = 1'b0; mem_lat = 1;
        served = 0;
        exp_d = 1'b1;
        for (int m = 0; m < 2; m++) begin
            cnt[m] = 0;
            adr[m] = 12'($urandom_range(0, 4095));
            set_master(m[0], 1'b1, 1'b0, adr[m], 16'hFFFF, '0);
            up[m] = 1'b1;
        end
        for (int c = 0; c < 300 && served < 2 * quota; c++) begin
            tick();
            for (int m = 0; m < 2; m++) begin
                ackv = m[0] ? bus.d_ack : bus.i_ack;
                if (ackv) begin
                    chk({nm, ".order"}, 128'(m[0]), 128'(exp_d));
                    chk({nm, ".dat_s"}, m[0] ? bus.d_dat_s : bus.i_dat_s, mem_word(adr[m]));
                    exp_d = ~exp_d;
                    served++;
                    cnt[m]++;
                    set_master(m[0], 1'b0, 1'b0, 12'h0, 16'h0, '0);
                    up[m] = 1'b0;
                end else if (!up[m] && cnt[m] < quota) begin
                    adr[m] = 12'($urandom_range(0, 4095));
                    set_master(m[0], 1'b1, 1'b0, adr[m], 16'hFFFF, '0);
                    up[m] = 1'b1;
                end
            end
        end
        chk({nm, ".served"}, 128'(served), 128'(2 * quota));
        set_master(1'b0, 1'b0, 1'b0, 12'h0, 16'h0, '0);
        set_master(1'b1, 1'b0, 1'b0, 12'h0, 16'h0, '0);
        tick();
    endtask

    // Random traffic; model: a grant goes to the lone requester, or to the master not served last.
    task automatic run_random(input int cycles);
        logic [11:0]  r_adr[2];
        logic         r_we[2];
        logic [15:0]  r_sel[2];
        logic [127:0] r_dat[2];
        bit up[2];
        int gap[2];
        bit last_d, owner, p_stb, comp, ri, rd, exp_ack;
        logic ackv[2];
        int done_n;
        reset_dut();
        fixed_en = 1'b0; mem_rand = 1'b1; mem_salt = $urandom;
        last_d = 1'b0; owner = 1'b0; p_stb = 1'b0; done_n = 0;
        for (int m = 0; m < 2; m++) begin
            up[m] = 1'b0; gap[m] = 0;
            r_adr[m] = '0; r_we[m] = 1'b0; r_sel[m] = '0; r_dat[m] = '0;
        end
        for (int c = 0; c < cycles + 60; c++) begin
            tick();
            comp = bus.m_ack && p_stb;
            if (comp) last_d = owner;
            ackv[0] = bus.i_ack;
            ackv[1] = bus.d_ack;
            for (int m = 0; m < 2; m++) begin
                exp_ack = comp && (owner == m[0]);
                chk("rnd.ack", 128'(ackv[m]), 128'(exp_ack));
                if (exp_ack) chk("rnd.dat_s", m[0] ? bus.d_dat_s : bus.i_dat_s, mem_word(r_adr[m]));
            end
            if (bus.m_stb && !p_stb) begin
                ri = bus.i_cyc & bus.i_stb;
                rd = bus.d_cyc & bus.d_stb;
                owner = (ri && rd) ? ~last_d : rd;
                chk("rnd.grant_has_req", 128'(ri | rd), 128'(1));
                chk("rnd.m_ctl", 128'({bus.m_adr, bus.m_sel, bus.m_we}),
                    128'({r_adr[owner], r_sel[owner], r_we[owner]}));
                chk("rnd.m_dat_m", bus.m_dat_m, r_dat[owner]);
            end
            p_stb = bus.m_stb;
            for (int m = 0; m < 2; m++) begin
                if (ackv[m]) begin
                    up[m] = 1'b0;
                    gap[m] = int'($urandom_range(0, 3));
                    set_master(m[0], 1'b0, 1'b0, 12'h0, 16'h0, '0);
                    done_n++;
                end else if (!up[m]) begin
                    if (gap[m] > 0) gap[m]--;
                    else if (c < cycles) begin
                        r_adr[m] = 12'($urandom_range(0, 4095));
                        r_we[m]  = 1'($urandom_range(0, 1));
                        r_sel[m] = 16'($urandom);
                        r_dat[m] = {$urandom, $urandom, $urandom, $urandom};
                        set_master(m[0], 1'b1, r_we[m], r_adr[m], r_sel[m], r_dat[m]);
                        up[m] = 1'b1;
                    end
                end
            end
        end
        chk("rnd.drained", 128'({up[0], up[1]}), 128'(0));
        chk("rnd.some_done", 128'(done_n > cycles / 20), 128'(1));
        mem_rand = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"lone_read", 1'b0, 1'b0, 12'h010, 16'hFFFF, 128'h0, 3, {16{8'hA5}}, 5, {16{8'hA5}}};
        vecs[1] = '{"i_min_lat", 1'b0, 1'b0, 12'hFFF, 16'h00FF, 128'h0, 0,
                    128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 2,
                    128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210};
        vecs[2] = '{"i_write", 1'b0, 1'b1, 12'h555, 16'hF00F, 128'hCAFE_F00D_0000_1111_2222_3333_4444_5555,
                    4, 128'h1, 6, 128'h1};
        vecs[3] = '{"d_read", 1'b1, 1'b0, 12'h000, 16'h0001, 128'h0, 2, {8{16'h5555}}, 4, {8{16'h5555}}};
        vecs[4] = '{"d_write", 1'b1, 1'b1, 12'h3FF, 16'h0030, 128'h0000_0000_0000_0000_0000_1234_0000_0000,
                    1, 128'hDEAD_BEEF, 3, 128'hDEAD_BEEF};
        rst_vec = '{"post_rst", 1'b1, 1'b0, 12'h7E1, 16'hFFFF, 128'h0, 0, 128'h77, 2, 128'h77};

        rst_n = 1'b0;
        set_master(1'b0, 1'b0, 1'b0, 12'h0, 16'h0, '0);
        set_master(1'b1, 1'b0, 1'b0, 12'h0, 16'h0, '0);
        tick();
        tick();
        zero_check("reset");
        rst_n = 1'b1;
        tick();
        zero_check("post_reset");

        run_pair("contend", 1);
        run_pair("fair", 3);

        for (int k = 0; k < 5; k++) run_vec(vecs[k]);

        // stray m_ack while idle must not produce an ack or start a cycle
        stray_ack = 1'b1;
        tick();
        stray_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stray.acks", 128'({bus.i_ack, bus.d_ack}), 128'(0));
            chk("stray.m_stb", 128'(bus.m_stb), 128'(0));
        end

        // abort: instruction master drops cyc mid-cycle; last served before this was D
        mem_hold = 1'b1;
        set_master(1'b0, 1'b1, 1'b0, 12'h0AB, 16'hFFFF, '0);
        for (int k = 0; k < 10 && !bus.m_stb; k++) tick();
        chk("abort.grant", 128'(bus.m_stb), 128'(1));
        tick();
        set_master(1'b0, 1'b0, 1'b0, 12'h0, 16'h0, '0);
        tick();
        chk("abort.hold1", 128'(bus.m_stb), 128'(1));
        tick();
        chk("abort.hold2", 128'(bus.m_stb), 128'(1));
        stray_ack = 1'b1;
        tick();
        stray_ack = 1'b0;
        mem_hold = 1'b0;
        chk("abort.released", 128'(bus.m_stb), 128'(0));
        chk("abort.no_ack1", 128'({bus.i_ack, bus.d_ack}), 128'(0));
        tick();
        chk("abort.no_ack2", 128'({bus.i_ack, bus.d_ack}), 128'(0));
        run_pair("post_abort", 1);

        // reset in the middle of a data-master cycle
        mem_hold = 1'b1;
        set_master(1'b1, 1'b1, 1'b0, 12'h123, 16'hFFFF, '0);
        for (int k = 0; k < 10 && !bus.m_stb; k++) tick();
        chk("rst_mid.grant", 128'(bus.m_stb), 128'(1));
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        zero_check("rst_mid");
        set_master(1'b1, 1'b0, 1'b0, 12'h0, 16'h0, '0);
        tick();
        tick();
        rst_n = 1'b1;
        mem_hold = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("rst_mid.no_stale", 128'({bus.i_ack, bus.d_ack, bus.m_stb}), 128'(0));
        end
        run_vec(rst_vec);

        run_random(2000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12, line address width (word address bits [15:4]).
REQ-002 Parameter DATA_W, default 128, line data width.
REQ-003 Parameter SEL_W, default 16, byte-select width (DATA_W/8).
REQ-004 Clocking: one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  system clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 i_cyc, i_stb, i_we  in  1 each  instruction-fetch master cycle, strobe and write enable.
REQ-008 i_adr  in  ADDR_W  instruction-fetch line address.
REQ-009 i_dat_m  in  DATA_W / i_sel  in  SEL_W  instruction-fetch write data and byte selects.
REQ-010 i_dat_s  out  DATA_W / i_ack  out  1  read data and acknowledge to the instruction-fetch master.
REQ-011 d_cyc, d_stb, d_we, d_adr, d_dat_m, d_sel  in  as i_*  data-memory master request.
REQ-012 d_dat_s  out  DATA_W / d_ack  out  1  read data and acknowledge to the data-memory master.
REQ-013 m_cyc, m_stb, m_we  out  1 each / m_adr  out  ADDR_W / m_dat_m  out  DATA_W / m_sel  out  SEL_W  request to the shared memory.
REQ-014 m_dat_s  in  DATA_W / m_ack  in  1  response from the shared memory.

Function
REQ-015 A master requests when its cyc and stb are both 1; it holds its request and all request fields stable until it sees its ack.
REQ-016 The FSM has states IDLE, BUSY_I, BUSY_D and DONE.
REQ-017 In IDLE with only one master requesting, the FSM grants that master: it goes to BUSY_I or BUSY_D and registers adr, dat_m, sel and we into m_* on the same edge.
REQ-018 In IDLE with both masters requesting, the FSM grants the master not granted last (last_grant register, round-robin).
REQ-019 In IDLE with no request, the FSM stays in IDLE.
REQ-020 In BUSY_x, m_cyc and m_stb are 1 and m_adr, m_dat_m, m_sel and m_we are constant.
REQ-021 On m_ack=1 in BUSY_x, the FSM registers m_dat_s into a response register, updates last_grant to x and moves to DONE.
REQ-022 In DONE, x_ack is 1 for exactly one cycle and x_dat_s equals the response register; m_cyc and m_stb are 0; the next state is IDLE.
REQ-023 The non-granted master's ack is 0 at all times; both acks are never 1 in the same cycle.
REQ-024 x_dat_s holds its last value when ack=0, and is meaningful only when ack=1.
REQ-025 Minimum latency: request in cycle 0, m_stb in cycle 1, m_ack in cycle 1, x_ack in cycle 2.
REQ-026 There is no upper wait bound; BUSY_x holds indefinitely until m_ack arrives.
REQ-027 Abort: if the granted master drops cyc in BUSY_x, m_cyc and m_stb stay 1 until m_ack.
REQ-028 In an abort, the response is discarded, no ack is issued, last_grant still updates, and DONE is skipped (BUSY_x goes to IDLE).
REQ-029 A request still present in the IDLE cycle after DONE is a new transaction; the master drops stb in the cycle after it sees ack.
REQ-030 m_ack received in IDLE or DONE is ignored.
REQ-031 Writes (we=1) follow the same protocol; the response data is still captured, and the master ignores it.

Reset
REQ-032 While rst_n=0: state=IDLE, last_grant=I (so the data master wins the first contention), and all m_* outputs, i_ack/d_ack, i_dat_s/d_dat_s and the response register are 0.
REQ-033 Reset asserted mid-transaction abandons it immediately; after rst_n deasserts, no stale ack is issued.

Verification
REQ-034 Lone read: i_cyc=i_stb=1, i_adr=12'h010; memory acks 3 cycles after m_stb with 128'hA5...A5 -> m_adr=12'h010, m_we=0, then one i_ack pulse with i_dat_s=A5...A5 and d_ack=0 throughout.
REQ-035 Contention after reset: both request in the same cycle -> data master served first, then instruction master; two i_ack/d_ack pulses never overlap.
REQ-036 Fairness: both masters request back-to-back for 6 transactions -> grants alternate D,I,D,I,D,I.
REQ-037 Write: d_we=1, d_adr=12'h3FF, d_sel=16'h0030, d_dat_m=128'h0000_1234<<32 -> m_* fields match exactly; one d_ack pulse.
REQ-038 Abort: i_cyc dropped while BUSY_I, m_ack arrives 2 cycles later -> m_stb held until m_ack, no i_ack, FSM returns to IDLE.
REQ-039 Reset mid-operation: rst_n pulled low in BUSY_D -> all outputs are 0 asynchronously; after release, no d_ack appears until a new request completes.
